// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the round-robin FIFO write arbiter.
// Also holds the pointer helper used by the arbiter top.
package fifo_arb_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int STATS_W        = 16;

  // Modulo-num increment of a requester index.
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or above
// rr_ptr_i, wrapping modulo N. Produces a one-hot grant, its index and a hit flag.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int c;

  // NOTE: every output gets a default before the search loop, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(rr_ptr_i) + k) % N;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        idx_o    = IW'(c);
        gnt_o[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among NUM_REQ
// producers. Define FIFO_ARB_STATS_EN to add grant/stall statistics outputs.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int FIFO_WIDTH = DEF_FIFO_WIDTH,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          ack_valid,
  output logic [ID_W-1:0]               ack_id,
  output logic                          err_overflow
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0]    grant_cnt,
  output logic [STATS_W-1:0]            stall_cycles
`endif
);

  arb_state_e              state_q;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         id_d1_q, id_d2_q;
  logic                    wr_en_q, pend_d2_q, err_q;
  logic [FIFO_WIDTH-1:0]   data_q, data_d;

  logic                    can_issue;
  logic                    grant;
  logic [NUM_REQ-1:0]      pick_gnt;
  logic [ID_W-1:0]         pick_idx;
  logic                    pick_any;

  // Reads in the same cycle are not credited, so an in-flight write into an
  // almost-full FIFO must block a further grant.
  assign can_issue = !fifo_full && !(fifo_almostfull && wr_en_q);

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick_gnt),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign grant = can_issue && pick_any && !rst;
  assign gnt   = grant ? pick_gnt : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    if (grant) begin
      rr_ptr_d = ID_W'(next_ptr(int'(pick_idx), NUM_REQ));
      data_d   = req_data[int'(pick_idx)*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      rr_ptr_q  <= '0;
      id_d1_q   <= '0;
      id_d2_q   <= '0;
      pend_d2_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q   <= grant;
      data_q    <= data_d;
      rr_ptr_q  <= rr_ptr_d;
      if (grant) id_d1_q <= pick_idx;
      pend_d2_q <= wr_en_q;
      id_d2_q   <= id_d1_q;
      if (fifo_overflow) err_q <= 1'b1;
    end
  end

  // Operating mode: STALL while throttled with demand, back to RUN as soon
  // as the FIFO can take a write (that cycle's grant still follows rr_ptr).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (!can_issue && |req) state_q <= ST_STALL;
        ST_STALL: if (can_issue)          state_q <= ST_RUN;
        default:                          state_q <= ST_RUN;
      endcase
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign ack_valid    = fifo_wr_ack && pend_d2_q;
  assign ack_id       = id_d2_q;
  assign err_overflow = err_q;

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0] grant_cnt_q [NUM_REQ];
  logic [STATS_W-1:0] stall_cycles_q;

  // NOTE: the counter array is architectural state, so it is cleared by
  // reset element by element, unlike a plain data RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && grant_cnt_q[i] != '1) grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
      end
      if (state_q == ST_STALL && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*STATS_W +: STATS_W] = grant_cnt_q[i];
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter against a small depth-8 FIFO flag model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     gnt;
  logic             fifo_wr_en;
  logic [W-1:0]     fifo_data_in;
  logic             fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow;
  logic             ack_valid;
  logic [1:0]       ack_id;
  logic             err_overflow;

  // FIFO flag model (no reads) with a count loader and force inputs.
  logic [3:0] cnt_q = 4'd0;
  logic       ack_q = 1'b0, ovf_q = 1'b0;
  logic       load_en = 1'b0, ack_force = 1'b0, ovf_force = 1'b0;
  logic [3:0] load_val = 4'd0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en) cnt_q <= load_val;
    else if (fifo_wr_en && cnt_q != 4'd8) cnt_q <= cnt_q + 4'd1;
    ack_q <= fifo_wr_en && (cnt_q != 4'd8);
    ovf_q <= fifo_wr_en && (cnt_q == 4'd8);
  end

  assign fifo_full       = (cnt_q == 4'd8);
  assign fifo_almostfull = (cnt_q == 4'd7);
  assign fifo_wr_ack     = ack_q | ack_force;
  assign fifo_overflow   = ovf_q | ovf_force;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_data        (req_data),
    .gnt             (gnt),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_wr_ack     (fifo_wr_ack),
    .fifo_overflow   (fifo_overflow),
    .ack_valid       (ack_valid),
    .ack_id          (ack_id),
    .err_overflow    (err_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int i);
    return 32'hD000 + 32'(i);
  endfunction

  function automatic logic [31:0] oh(input int i);
    return 32'(1) << i;
  endfunction

  // Loads the model count over one clock with requests idle.
  task automatic load_cnt(input logic [3:0] v);
    req      = '0;
    load_val = v;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(dat(i));
    repeat (2) @(negedge clk);

    // Reset state and gnt forced low during reset
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_data", 32'(fifo_data_in), 0);
    check("rst_ack", 32'(ack_valid), 0);
    check("rst_err", 32'(err_overflow), 0);
    req = 4'hF;
    #1 check("rst_gnt", 32'(gnt), 0);
    rst = 1'b0;

    // Tests 1/2: all requesting, empty depth-8 FIFO, no reads
    for (int k = 0; k < 8; k++) begin
      #1 check($sformatf("rr_gnt%0d", k), 32'(gnt), oh(k % 4));
      @(negedge clk);
      check($sformatf("rr_wr_en%0d", k), 32'(fifo_wr_en), 1);
      check($sformatf("rr_data%0d", k), 32'(fifo_data_in), dat(k % 4));
    end
    #1 check("af_inflight_gnt", 32'(gnt), 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("full_gnt%0d", k), 32'(gnt), 0);
      check($sformatf("full_wr_en%0d", k), 32'(fifo_wr_en), 0);
      check($sformatf("full_state%0d", k), 32'(dut.state_q), 32'(ST_STALL));
      check($sformatf("full_hold%0d", k), 32'(fifo_data_in), dat(3));
      check($sformatf("full_err%0d", k), 32'(err_overflow), 0);
      @(negedge clk);
    end

    // Test 3: almostfull with no write in flight grants exactly once
    load_cnt(4'd7);
    req = 4'b0001;
    #1 check("af_one_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    check("af_wr_en", 32'(fifo_wr_en), 1);
    check("af_data", 32'(fifo_data_in), dat(0));
    check("af_state_run", 32'(dut.state_q), 32'(ST_RUN));
    #1 check("af_block_gnt", 32'(gnt), 0);
    @(negedge clk);
    #1 check("af_full_gnt", 32'(gnt), 0);
    check("af_full_state", 32'(dut.state_q), 32'(ST_STALL));

    // Test 4: single transfer latency, accept N / write N+1 / ack N+2
    load_cnt(4'd0);
    req = 4'b0100;
    #1 check("lat_gnt", 32'(gnt), 32'h4);
    check("lat_ack_n", 32'(ack_valid), 0);
    @(negedge clk);
    req = '0;
    check("lat_wr_en", 32'(fifo_wr_en), 1);
    check("lat_data", 32'(fifo_data_in), dat(2));
    check("lat_ack_n1", 32'(ack_valid), 0);
    @(negedge clk);
    check("lat_ack_n2", 32'(ack_valid), 1);
    check("lat_ack_id", 32'(ack_id), 2);
    check("lat_wr_en_n2", 32'(fifo_wr_en), 0);
    @(negedge clk);
    check("lat_ack_n3", 32'(ack_valid), 0);

    // Test 5: lone requester gets back-to-back grants, pointer stays at 2
    load_cnt(4'd0);
    req = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1 check($sformatf("solo_gnt%0d", k), 32'(gnt), 32'h2);
      @(negedge clk);
      check($sformatf("solo_wr_en%0d", k), 32'(fifo_wr_en), 1);
    end
    req = 4'hF;
    #1 check("solo_next_gnt", 32'(gnt), 32'h4);
    @(negedge clk);

    // Test 6: reset while a write is in flight
    check("mid_wr_en_pre", 32'(fifo_wr_en), 1);
    rst = 1'b1;
    #1 check("mid_rst_gnt", 32'(gnt), 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1010;
    check("mid_wr_en", 32'(fifo_wr_en), 0);
    check("mid_ack_dropped", 32'(ack_valid), 0);
    #1 check("mid_regrant", 32'(gnt), 32'h2);
    @(negedge clk);
    req = '0;
    check("mid_wr_en2", 32'(fifo_wr_en), 1);
    check("mid_data2", 32'(fifo_data_in), dat(1));
    check("mid_ack2", 32'(ack_valid), 0);
    @(negedge clk);
    check("mid_ack3", 32'(ack_valid), 1);
    check("mid_ack_id3", 32'(ack_id), 1);

    // Stray wr_ack with nothing pending is ignored
    @(negedge clk);
    ack_force = 1'b1;
    #1 check("stray_ack", 32'(ack_valid), 0);
    ack_force = 1'b0;

    // Sticky overflow error, cleared only by reset
    ovf_force = 1'b1;
    @(negedge clk);
    ovf_force = 1'b0;
    check("ovf_set", 32'(err_overflow), 1);
    @(negedge clk);
    check("ovf_sticky", 32'(err_overflow), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ovf_cleared", 32'(err_overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
